// File: rtl/ex_muldiv_seq_if.sv
// Bundle between the EX stage and the multiply/divide sequencer: operand request,
// pipeline stall, HI/LO view and the MF result path.
interface ex_muldiv_seq_if #(
  parameter int WIDTH = 32
) ();
  // start is a request held by the pipeline; it is taken on the rising edge where
  // start=1 and stall=0, and must stay stable with its operands while stall=1.
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] opb;
  logic             flush;
  logic             stall;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic [WIDTH-1:0] mf_out;
  logic [1:0]       dbg_state;

  modport master (
    output start, op, opa, opb, flush,
    input  stall, busy, done, hi, lo, mf_out, dbg_state
  );

  modport slave (
    input  start, op, opa, opb, flush,
    output stall, busy, done, hi, lo, mf_out, dbg_state
  );
endinterface

// File: rtl/ex_muldiv_seq.sv
// Iterative multiply/divide sequencer owning HI/LO: one bit per cycle for WIDTH
// cycles, then a sign-fixup cycle that commits the result.
module ex_muldiv_seq #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic            clk,
  input  logic            reset,
  ex_muldiv_seq_if.slave  bus
);

  localparam logic [2:0] OP_MTHI = 3'b100;
  localparam logic [2:0] OP_MTLO = 3'b101;
  localparam logic [2:0] OP_MFHI = 3'b110;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_FIXUP = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [CNT_W-1:0]   r_cnt;
  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH-1:0]   r_b;
  logic [WIDTH-1:0]   r_orig_a;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic               r_is_div;
  logic               r_neg_res;
  logic               r_neg_rem;
  logic               r_div0;
  logic               r_done;

  logic               w_last;
  logic               w_signed;
  logic               w_take;
  logic [WIDTH-1:0]   w_abs_a;
  logic [WIDTH-1:0]   w_abs_b;
  logic [WIDTH:0]     w_mul_sum;
  logic [2*WIDTH-1:0] w_mul_nxt;
  logic [WIDTH:0]     w_div_sh;
  logic [WIDTH:0]     w_div_diff;
  logic [2*WIDTH-1:0] w_div_nxt;
  logic [2*WIDTH-1:0] w_prod_fix;
  logic [WIDTH-1:0]   w_quo_fix;
  logic [WIDTH-1:0]   w_rem_fix;
  logic [WIDTH-1:0]   w_res_hi;
  logic [WIDTH-1:0]   w_res_lo;

  assign w_last   = (r_cnt == CNT_W'(WIDTH - 1));
  assign w_signed = ~bus.op[0];
  assign w_take   = bus.start & ~bus.flush;
  assign w_abs_a  = (w_signed && bus.opa[WIDTH-1]) ? -bus.opa : bus.opa;
  assign w_abs_b  = (w_signed && bus.opb[WIDTH-1]) ? -bus.opb : bus.opb;

  // Multiply: upper half accumulates the multiplicand while the multiplier shifts out the bottom.
  assign w_mul_sum = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_b} : '0);
  assign w_mul_nxt = {w_mul_sum, r_acc[WIDTH-1:1]};

  // Divide: upper half is the partial remainder, lower half shifts dividend out and quotient in.
  assign w_div_sh   = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
  assign w_div_diff = w_div_sh - {1'b0, r_b};
  assign w_div_nxt  = w_div_diff[WIDTH] ? {w_div_sh[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0}
                                        : {w_div_diff[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};

  assign w_prod_fix = r_neg_res ? -r_acc : r_acc;
  assign w_quo_fix  = r_neg_res ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
  assign w_rem_fix  = r_neg_rem ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];

  // A zero divisor returns the untouched dividend and an all-ones quotient regardless of signs.
  always_comb begin
    w_res_hi = w_prod_fix[2*WIDTH-1:WIDTH];
    w_res_lo = w_prod_fix[WIDTH-1:0];
    if (r_is_div) begin
      if (r_div0) begin
        w_res_hi = r_orig_a;
        w_res_lo = '1;
      end else begin
        w_res_hi = w_rem_fix;
        w_res_lo = w_quo_fix;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_take && !bus.op[2]) w_state_nxt = S_RUN;
      S_RUN:   if (bus.flush)            w_state_nxt = S_IDLE;
               else if (w_last)          w_state_nxt = S_FIXUP;
      S_FIXUP: w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt     <= '0;
      r_acc     <= '0;
      r_b       <= '0;
      r_orig_a  <= '0;
      r_hi      <= '0;
      r_lo      <= '0;
      r_is_div  <= 1'b0;
      r_neg_res <= 1'b0;
      r_neg_rem <= 1'b0;
      r_div0    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_take && !bus.op[2]) begin
            r_cnt     <= '0;
            r_is_div  <= bus.op[1];
            r_orig_a  <= bus.opa;
            r_div0    <= (bus.opb == '0);
            r_neg_res <= w_signed & (bus.opa[WIDTH-1] ^ bus.opb[WIDTH-1]);
            r_neg_rem <= w_signed & bus.opa[WIDTH-1];
            r_b       <= bus.op[1] ? w_abs_b : w_abs_a;
            r_acc     <= {{WIDTH{1'b0}}, (bus.op[1] ? w_abs_a : w_abs_b)};
          end else if (w_take && bus.op == OP_MTHI) begin
            r_hi <= bus.opa;
          end else if (w_take && bus.op == OP_MTLO) begin
            r_lo <= bus.opa;
          end
        end
        S_RUN: begin
          if (bus.flush) begin
            r_cnt <= '0;
          end else begin
            r_acc <= r_is_div ? w_div_nxt : w_mul_nxt;
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_FIXUP: begin
          r_cnt <= '0;
          if (!bus.flush) begin
            r_hi   <= w_res_hi;
            r_lo   <= w_res_lo;
            r_done <= 1'b1;
          end
        end
        default: r_cnt <= '0;
      endcase
    end
  end

  assign bus.busy      = (r_state != S_IDLE);
  assign bus.stall     = bus.start & bus.busy;
  assign bus.done      = r_done;
  assign bus.hi        = r_hi;
  assign bus.lo        = r_lo;
  assign bus.mf_out    = (bus.op == OP_MFHI) ? r_hi : r_lo;
  assign bus.dbg_state = r_state;

endmodule

// File: tb/tb_ex_muldiv_seq.sv
// Directed bench for ex_muldiv_seq: arithmetic results, latency, stall on busy,
// flush and reset behaviour, and HI/LO moves.
module tb_ex_muldiv_seq;
  localparam int W = 32;
  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;
  localparam logic [2:0] OP_MFHI  = 3'b110;
  localparam logic [2:0] OP_MFLO  = 3'b111;

  logic clk = 1'b0;
  logic reset;
  int   n_pass = 0;
  int   n_checks = 0;

  ex_muldiv_seq_if #(.WIDTH(W)) bus ();

  ex_muldiv_seq #(.WIDTH(W), .CNT_W(6)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic drive(input logic st, input logic [2:0] op, input logic [W-1:0] a,
                       input logic [W-1:0] b);
    bus.start = st;
    bus.op    = op;
    bus.opa   = a;
    bus.opb   = b;
  endtask

  // Called at the negedge of the first busy cycle; counts edges until done is seen.
  task automatic wait_done(output int edges, output int busy_n);
    edges  = 0;
    busy_n = 0;
    while (bus.done !== 1'b1 && edges < 100) begin
      if (bus.busy === 1'b1) busy_n++;
      @(negedge clk);
      edges++;
    end
  endtask

  task automatic run_op(input string tag, input logic [2:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [W-1:0] exp_hi,
                        input logic [W-1:0] exp_lo);
    int e, bn;
    @(negedge clk);
    drive(1'b1, op, a, b);
    @(negedge clk);
    bus.start = 1'b0;
    wait_done(e, bn);
    chk({tag, " edges"}, 32'(e), 32'd33);
    chk({tag, " hi"}, bus.hi, exp_hi);
    chk({tag, " lo"}, bus.lo, exp_lo);
  endtask

  initial begin
    int e, bn, stall_n, done_n;
    reset     = 1'b1;
    bus.flush = 1'b0;
    drive(1'b0, OP_MULT, '0, '0);
    repeat (3) @(negedge clk);
    chk("reset hi", bus.hi, 32'h0);
    chk("reset lo", bus.lo, 32'h0);
    chk("reset busy", 32'(bus.busy), 32'd0);
    chk("reset done", 32'(bus.done), 32'd0);
    chk("reset stall", 32'(bus.stall), 32'd0);
    chk("reset state", 32'(bus.dbg_state), 32'd0);
    reset = 1'b0;

    // MULT 7*6 with latency and busy-width checks
    @(negedge clk);
    drive(1'b1, OP_MULT, 32'd7, 32'd6);
    @(negedge clk);
    bus.start = 1'b0;
    wait_done(e, bn);
    chk("mult7x6 edges", 32'(e), 32'd33);
    chk("mult7x6 busy cycles", 32'(bn), 32'd33);
    chk("mult7x6 hi", bus.hi, 32'h0);
    chk("mult7x6 lo", bus.lo, 32'd42);
    chk("mult7x6 busy in done cycle", 32'(bus.busy), 32'd0);
    @(negedge clk);
    chk("done one cycle", 32'(bus.done), 32'd0);

    run_op("multu max", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
    run_op("mult -3x5", OP_MULT, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1);
    run_op("div -7/2", OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("div 7/-2", OP_DIV, 32'd7, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD);
    run_op("divu 100/7", OP_DIVU, 32'd100, 32'd7, 32'd2, 32'd14);
    run_op("divu 100/0", OP_DIVU, 32'd100, 32'd0, 32'd100, 32'hFFFF_FFFF);
    run_op("div -5/0", OP_DIV, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 32'hFFFF_FFFF);
    run_op("div min/-1", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000);

    // MFLO held from the 5th busy cycle of a MULT
    @(negedge clk);
    drive(1'b1, OP_MULT, 32'd12, 32'd11);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (4) @(negedge clk);
    drive(1'b1, OP_MFLO, '0, '0);
    #1;
    stall_n = 0;
    e = 0;
    while (bus.done !== 1'b1 && e < 100) begin
      if (bus.stall === 1'b1) stall_n++;
      @(negedge clk);
      e++;
    end
    chk("mflo stall cycles", 32'(stall_n), 32'd29);
    chk("mflo stall in done cycle", 32'(bus.stall), 32'd0);
    chk("mflo mf_out", bus.mf_out, 32'd132);
    @(negedge clk);
    bus.start = 1'b0;
    chk("mflo no restart", 32'(bus.busy), 32'd0);

    // back-to-back: second op held through the first, accepted in the done cycle
    @(negedge clk);
    drive(1'b1, OP_MULT, 32'd2, 32'd3);
    @(negedge clk);
    drive(1'b1, OP_MULTU, 32'd4, 32'd5);
    wait_done(e, bn);
    chk("b2b first lo", bus.lo, 32'd6);
    @(negedge clk);
    bus.start = 1'b0;
    chk("b2b second accepted", 32'(bus.busy), 32'd1);
    wait_done(e, bn);
    chk("b2b second edges", 32'(e), 32'd33);
    chk("b2b second lo", bus.lo, 32'd20);

    // MTHI / MTLO / MFHI
    @(negedge clk);
    drive(1'b1, OP_MTHI, 32'h0000_1234, '0);
    @(negedge clk);
    drive(1'b1, OP_MTLO, 32'h0000_5678, '0);
    @(negedge clk);
    drive(1'b1, OP_MFHI, '0, '0);
    #1;
    chk("mthi hi", bus.hi, 32'h0000_1234);
    chk("mtlo lo", bus.lo, 32'h0000_5678);
    chk("mfhi mf_out", bus.mf_out, 32'h0000_1234);
    chk("mfhi stall", 32'(bus.stall), 32'd0);

    // flush with start in IDLE: MT suppressed, mul/div dropped
    @(negedge clk);
    drive(1'b1, OP_MTHI, 32'hDEAD_BEEF, '0);
    bus.flush = 1'b1;
    @(negedge clk);
    drive(1'b1, OP_DIV, 32'd50, 32'd5);
    @(negedge clk);
    bus.start = 1'b0;
    bus.flush = 1'b0;
    chk("flushed mthi", bus.hi, 32'h0000_1234);
    chk("flushed div dropped", 32'(bus.busy), 32'd0);

    // flush at the 10th RUN cycle
    @(negedge clk);
    drive(1'b1, OP_DIV, 32'd100, 32'd3);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (9) @(negedge clk);
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    chk("flush10 idle", 32'(bus.busy), 32'd0);
    done_n = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus.done === 1'b1) done_n++;
      @(negedge clk);
    end
    chk("flush10 no done", 32'(done_n), 32'd0);
    chk("flush10 hi", bus.hi, 32'h0000_1234);
    chk("flush10 lo", bus.lo, 32'h0000_5678);

    // flush on the last RUN cycle wins over the result
    @(negedge clk);
    drive(1'b1, OP_MULTU, 32'd9, 32'd9);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (31) @(negedge clk);
    chk("last run cycle busy", 32'(bus.busy), 32'd1);
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    chk("flushlast idle", 32'(bus.busy), 32'd0);
    done_n = 0;
    for (int i = 0; i < 5; i++) begin
      if (bus.done === 1'b1) done_n++;
      @(negedge clk);
    end
    chk("flushlast no done", 32'(done_n), 32'd0);
    chk("flushlast lo", bus.lo, 32'h0000_5678);

    // reset in the middle of RUN
    @(negedge clk);
    drive(1'b1, OP_MULT, 32'd3, 32'd3);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (4) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("midreset busy", 32'(bus.busy), 32'd0);
    chk("midreset hi", bus.hi, 32'h0);
    chk("midreset lo", bus.lo, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
